chan_fifo_bridge: RTL and testbench

- Parametrised multi-channel successor to the plain width-parametrised port-to-port connection.
- Carries CHANNELS independent WIDTH-bit streams from a producer to a consumer, each through its own DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Adds per-channel buffering, backpressure, flush and occupancy reporting; a straight connection has none of these.
- Sits between a test-bench-facing connection interface and downstream sub-blocks.

---
 rtl/chan_fifo_bridge.sv | 82 ++++++++
 tb/tb_chan_fifo_bridge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/chan_fifo_bridge.sv
// Multi-channel valid/ready bridge: one independent DEPTH-entry FIFO per channel
// with per-channel flush and registered occupancy reporting.
module chan_fifo_bridge #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 4,
  parameter int LW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  input  logic [CHANNELS-1:0]       flush,
  output logic [CHANNELS*LW-1:0]    level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH need not be a power of two, so wrap explicitly at DEPTH-1.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [LW-1:0]    count_q, count_d;
      logic             full, empty, push, pop;

      always_comb begin
        full     = (count_q == LW'(DEPTH));
        empty    = (count_q == '0);
        push     = in_valid[c] & ~full;
        pop      = out_ready[c] & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush[c]) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end else begin
          if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
          if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
          if (push && !pop)      count_d = count_q + LW'(1);
          else if (pop && !push) count_d = count_q - LW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      // Storage carries no reset; out_data is only meaningful while out_valid is high.
      always_ff @(posedge clk) begin
        if (push && !flush[c]) mem_q[wr_ptr_q] <= in_data[c*WIDTH +: WIDTH];
      end

      assign in_ready[c]                 = ~full;
      assign out_valid[c]                = ~empty;
      assign out_data[c*WIDTH +: WIDTH]  = mem_q[rd_ptr_q];
      assign level[c*LW +: LW]           = count_q;
    end
  endgenerate

endmodule

// File: tb/tb_chan_fifo_bridge.sv
// Directed bench for chan_fifo_bridge: a 2-channel DEPTH=4 instance and a
// 1-channel DEPTH=3 instance for pointer wrap-around.
module tb_chan_fifo_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, CHANNELS=2, DEPTH=4 -> LW=3
  logic [15:0] a_in_data  = '0;
  logic [1:0]  a_in_valid = '0;
  logic [1:0]  a_in_ready;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_valid;
  logic [1:0]  a_out_ready = '0;
  logic [1:0]  a_flush     = '0;
  logic [5:0]  a_level;

  // Instance B: WIDTH=8, CHANNELS=1, DEPTH=3 -> LW=2
  logic [7:0]  b_in_data  = '0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_out_data;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic        b_flush     = 1'b0;
  logic [1:0]  b_level;

  chan_fifo_bridge #(.WIDTH(8), .CHANNELS(2), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .flush(a_flush), .level(a_level)
  );

  chan_fifo_bridge #(.WIDTH(8), .CHANNELS(1), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .flush(b_flush), .level(b_level)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] lvl_a(input int unsigned ch);
    return a_level[ch*3 +: 3];
  endfunction

  function automatic logic [7:0] dat_a(input int unsigned ch);
    return a_out_data[ch*8 +: 8];
  endfunction

  logic [7:0] model_q[$];

  initial begin
    #12;
    check("rst_hold_out_valid", {30'd0, a_out_valid}, 32'h0);
    check("rst_hold_in_ready", {30'd0, a_in_ready}, 32'h3);
    tick();
    rst = 1'b0;

    // Asynchronous reset mid-cycle drops stored data immediately
    a_in_valid = 2'b01; a_in_data = 16'h0011;
    tick();
    a_in_valid = 2'b00;
    check("pre_rst_valid", {30'd0, a_out_valid}, 32'h1);
    check("pre_rst_level0", {29'd0, lvl_a(0)}, 32'd1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_out_valid", {30'd0, a_out_valid}, 32'h0);
    check("async_rst_in_ready", {30'd0, a_in_ready}, 32'h3);
    check("async_rst_level", {26'd0, a_level}, 32'h0);
    check("async_rst_b_level", {30'd0, b_level}, 32'h0);
    tick();
    rst = 1'b0;

    // Fill ch0 to DEPTH with the consumer stalled; a 5th push is refused
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 2'b01; a_in_data = {8'h00, 8'(i)};
      tick();
    end
    check("fill_level0", {29'd0, lvl_a(0)}, 32'd4);
    check("fill_in_ready0", {31'd0, a_in_ready[0]}, 32'd0);
    a_in_data = 16'h0005;
    tick();
    a_in_valid = 2'b00;
    check("full_refuse_level0", {29'd0, lvl_a(0)}, 32'd4);
    check("full_ch1_untouched", {29'd0, lvl_a(1)}, 32'd0);

    a_out_ready = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid0", {31'd0, a_out_valid[0]}, 32'd1);
      check("drain_data0", {24'd0, dat_a(0)}, i);
      tick();
    end
    a_out_ready = 2'b00;
    check("drained_level0", {29'd0, lvl_a(0)}, 32'd0);
    check("drained_valid0", {31'd0, a_out_valid[0]}, 32'd0);

    // Full plus pop: first cycle only pops, next cycle accepts the push
    for (int i = 1; i <= 4; i++) begin
      a_in_valid = 2'b01; a_in_data = {8'h00, 8'(8'h20 + i)};
      tick();
    end
    a_in_data = 16'h0025; a_out_ready = 2'b01;
    tick();
    check("fullpop_level0", {29'd0, lvl_a(0)}, 32'd3);
    check("fullpop_in_ready0", {31'd0, a_in_ready[0]}, 32'd1);
    check("fullpop_head", {24'd0, dat_a(0)}, 32'h22);
    tick();
    a_in_valid = 2'b00;
    check("pushpop_level0", {29'd0, lvl_a(0)}, 32'd3);
    for (int i = 3; i <= 5; i++) begin
      check("fullpop_drain", {24'd0, dat_a(0)}, 32'h20 + i);
      tick();
    end
    a_out_ready = 2'b00;
    check("fullpop_empty", {29'd0, lvl_a(0)}, 32'd0);

    // ch1 holds three entries, then flush[1] with a concurrent push while ch0 streams
    for (int i = 1; i <= 3; i++) begin
      a_in_valid = 2'b10; a_in_data = {8'(8'h30 + i), 8'h00};
      tick();
    end
    check("ch1_level3", {29'd0, lvl_a(1)}, 32'd3);
    a_in_valid = 2'b11; a_in_data = 16'h3441; a_flush = 2'b10;
    tick();
    a_flush = 2'b00;
    check("flush_level1", {29'd0, lvl_a(1)}, 32'd0);
    check("flush_valid1", {31'd0, a_out_valid[1]}, 32'd0);
    check("flush_ch0_level", {29'd0, lvl_a(0)}, 32'd1);
    check("flush_ch0_data", {24'd0, dat_a(0)}, 32'h41);
    a_in_data = 16'h3542;
    tick();
    a_in_valid = 2'b00;
    check("post_flush_data1", {24'd0, dat_a(1)}, 32'h35);
    check("post_flush_level1", {29'd0, lvl_a(1)}, 32'd1);
    check("ch0_level2", {29'd0, lvl_a(0)}, 32'd2);
    a_out_ready = 2'b01;
    check("ch0_stream_a", {24'd0, dat_a(0)}, 32'h41);
    tick();
    check("ch0_stream_b", {24'd0, dat_a(0)}, 32'h42);
    tick();
    a_out_ready = 2'b00;
    check("ch0_stream_empty", {29'd0, lvl_a(0)}, 32'd0);
    check("ch1_still_one", {29'd0, lvl_a(1)}, 32'd1);

    // DEPTH=3: hold count at 2 with simultaneous push/pop, forcing pointer wrap
    for (int i = 1; i <= 2; i++) begin
      b_in_valid = 1'b1; b_in_data = 8'(i);
      model_q.push_back(8'(i));
      tick();
    end
    b_in_valid = 1'b0;
    check("b_level2", {30'd0, b_level}, 32'd2);
    b_out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_in_valid = 1'b1; b_in_data = 8'(8'h0A + k);
      check("b_wrap_head", {24'd0, b_out_data}, {24'd0, model_q[0]});
      void'(model_q.pop_front());
      model_q.push_back(8'(8'h0A + k));
      tick();
      check("b_wrap_level", {30'd0, b_level}, 32'd2);
    end
    b_in_valid = 1'b0;
    while (model_q.size() != 0) begin
      check("b_tail_data", {24'd0, b_out_data}, {24'd0, model_q[0]});
      void'(model_q.pop_front());
      tick();
    end
    b_out_ready = 1'b0;
    check("b_final_valid", {31'd0, b_out_valid}, 32'd0);
    check("b_final_ready", {31'd0, b_in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
